// File: rtl/rs_array.sv
// rs_array: multi-entry Tomasulo reservation station with CDB snooping and one dispatch per cycle.
// Define RS_AGE_ORDER_EN to dispatch the oldest ready entry instead of the lowest-index one.
module rs_array #(
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 4,
  parameter int OP_W     = 3,
  parameter int TAG_BASE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [OP_W-1:0]            issue_op,
  input  logic [DATA_W-1:0]          issue_vj,
  input  logic [TAG_W-1:0]           issue_qj,
  input  logic [DATA_W-1:0]          issue_vk,
  input  logic [TAG_W-1:0]           issue_qk,
  output logic [TAG_W-1:0]           issue_tag,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [DATA_W-1:0]          cdb_data,
  output logic                       disp_valid,
  input  logic                       disp_ready,
  output logic [OP_W-1:0]            disp_op,
  output logic [DATA_W-1:0]          disp_vj,
  output logic [DATA_W-1:0]          disp_vk,
  output logic [TAG_W-1:0]           disp_tag,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       full,
  output logic                       empty
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [TAG_W-1:0]  qj;
    logic [TAG_W-1:0]  qk;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [DEPTH-1:0] ready;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic [OCC_W-1:0] occ;
  logic             issue_fire;
  logic             disp_fire;
  logic             bypass_j;
  logic             bypass_k;

  always_comb begin
    free_idx = '0;
    occ      = '0;
    ready    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_q[i].valid) free_idx = IDX_W'(i);
      occ      = occ + OCC_W'(ent_q[i].valid);
      ready[i] = ent_q[i].valid && (ent_q[i].qj == '0) && (ent_q[i].qk == '0);
    end
  end

  assign occupancy   = occ;
  assign full        = (occ == OCC_W'(DEPTH));
  assign empty       = (occ == '0);
  assign issue_ready = !full;
  assign issue_tag   = full ? '0 : (TAG_W'(TAG_BASE) + TAG_W'(free_idx));
  assign issue_fire  = issue_valid && issue_ready;
  assign disp_valid  = |ready;
  assign disp_fire   = disp_valid && disp_ready;

`ifdef RS_AGE_ORDER_EN
  logic [IDX_W-1:0] age_q [DEPTH];
  logic [IDX_W-1:0] age_d [DEPTH];
  logic [IDX_W-1:0] best_age;
  logic             sel_found;

  // Oldest ready entry wins; strict compare keeps ties on the lowest index.
  always_comb begin
    sel_idx   = '0;
    best_age  = '0;
    sel_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!sel_found || age_q[i] > best_age)) begin
        sel_idx   = IDX_W'(i);
        best_age  = age_q[i];
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_d[i] = age_q[i];
      if (issue_fire) begin
        if (free_idx == IDX_W'(i)) begin
          age_d[i] = '0;
        end else if (ent_q[i].valid && (age_q[i] != '1)) begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
    end
  end
`else
  always_comb begin
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) sel_idx = IDX_W'(i);
    end
  end
`endif

  assign disp_op  = disp_valid ? ent_q[sel_idx].op : '0;
  assign disp_vj  = disp_valid ? ent_q[sel_idx].vj : '0;
  assign disp_vk  = disp_valid ? ent_q[sel_idx].vk : '0;
  assign disp_tag = disp_valid ? (TAG_W'(TAG_BASE) + TAG_W'(sel_idx)) : '0;

  // A broadcast on the issuing cycle is forwarded so the new entry never misses its producer.
  assign bypass_j = cdb_valid && (issue_qj != '0) && (issue_qj == cdb_tag);
  assign bypass_k = cdb_valid && (issue_qk != '0) && (issue_qk == cdb_tag);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].valid && cdb_valid && (ent_q[i].qj != '0) && (ent_q[i].qj == cdb_tag)) begin
        ent_d[i].vj = cdb_data;
        ent_d[i].qj = '0;
      end
      if (ent_q[i].valid && cdb_valid && (ent_q[i].qk != '0) && (ent_q[i].qk == cdb_tag)) begin
        ent_d[i].vk = cdb_data;
        ent_d[i].qk = '0;
      end
      if (disp_fire && (sel_idx == IDX_W'(i))) ent_d[i].valid = 1'b0;
      if (issue_fire && (free_idx == IDX_W'(i))) begin
        ent_d[i].valid = 1'b1;
        ent_d[i].op    = issue_op;
        ent_d[i].vj    = bypass_j ? cdb_data : issue_vj;
        ent_d[i].qj    = bypass_j ? '0 : issue_qj;
        ent_d[i].vk    = bypass_k ? cdb_data : issue_vk;
        ent_d[i].qk    = bypass_k ? '0 : issue_qk;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: tb/tb_rs_array.sv
// tb_rs_array: directed and randomized scoreboard bench for rs_array against a behavioural model.
// Honours RS_AGE_ORDER_EN in its model so it matches either build of the design.
module tb_rs_array;
  localparam int DEPTH    = 4;
  localparam int DATA_W   = 32;
  localparam int TAG_W    = 4;
  localparam int OP_W     = 3;
  localparam int TAG_BASE = 1;
  localparam int OCC_W    = $clog2(DEPTH + 1);
  localparam int AGE_MAX  = (1 << $clog2(DEPTH)) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              issue_valid = 1'b0;
  logic              issue_ready;
  logic [OP_W-1:0]   issue_op = '0;
  logic [DATA_W-1:0] issue_vj = '0;
  logic [TAG_W-1:0]  issue_qj = '0;
  logic [DATA_W-1:0] issue_vk = '0;
  logic [TAG_W-1:0]  issue_qk = '0;
  logic [TAG_W-1:0]  issue_tag;
  logic              cdb_valid = 1'b0;
  logic [TAG_W-1:0]  cdb_tag = '0;
  logic [DATA_W-1:0] cdb_data = '0;
  logic              disp_valid;
  logic              disp_ready = 1'b0;
  logic [OP_W-1:0]   disp_op;
  logic [DATA_W-1:0] disp_vj;
  logic [DATA_W-1:0] disp_vk;
  logic [TAG_W-1:0]  disp_tag;
  logic [OCC_W-1:0]  occupancy;
  logic              full;
  logic              empty;

  always #5 clk = ~clk;

  rs_array #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W), .TAG_BASE(TAG_BASE)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_qj(issue_qj), .issue_vk(issue_vk), .issue_qk(issue_qk),
    .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_tag(disp_tag),
    .occupancy(occupancy), .full(full), .empty(empty)
  );

  // Model entry: seq records the global issue count at allocation, so age is a subtraction.
  typedef struct {
    bit          valid;
    int unsigned op, vj, vk, qj, qk, seq;
  } mentry_t;

  typedef struct {
    bit          ready_o, full_o, empty_o, dvalid;
    int unsigned tag, occ, dop, dvj, dvk, dtag;
  } status_t;

  typedef struct {
    int unsigned op, vj, vk, tag;
  } disp_t;

  mentry_t     mdl [DEPTH];
  int unsigned issue_count = 0;
  status_t     sq[$];
  disp_t       dq[$];
  int          checks = 0;
  int          errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int modelFree();
    for (int i = 0; i < DEPTH; i++) if (!mdl[i].valid) return i;
    return -1;
  endfunction

  function automatic int modelSelect();
    int best = -1;
`ifdef RS_AGE_ORDER_EN
    int unsigned best_age = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mdl[i].valid && mdl[i].qj == 0 && mdl[i].qk == 0) begin
        int unsigned a = issue_count - mdl[i].seq;
        if (a > AGE_MAX) a = AGE_MAX;
        if (best < 0 || a > best_age) begin
          best     = i;
          best_age = a;
        end
      end
    end
`else
    for (int i = 0; i < DEPTH; i++) begin
      if (best < 0 && mdl[i].valid && mdl[i].qj == 0 && mdl[i].qk == 0) best = i;
    end
`endif
    return best;
  endfunction

  function automatic status_t modelStatus();
    status_t s;
    int fi = modelFree();
    int si = modelSelect();
    int n  = 0;
    for (int i = 0; i < DEPTH; i++) if (mdl[i].valid) n++;
    s.ready_o = (fi >= 0);
    s.tag     = (fi >= 0) ? int'(TAG_BASE + fi) : 0;
    s.occ     = n;
    s.full_o  = (n == DEPTH);
    s.empty_o = (n == 0);
    s.dvalid  = (si >= 0);
    s.dop     = (si >= 0) ? mdl[si].op : 0;
    s.dvj     = (si >= 0) ? mdl[si].vj : 0;
    s.dvk     = (si >= 0) ? mdl[si].vk : 0;
    s.dtag    = (si >= 0) ? int'(TAG_BASE + si) : 0;
    return s;
  endfunction

  // Drives one cycle, queues what the DUT must show, then advances the model past the edge.
  task automatic applyStimulus(input bit iv, input int unsigned op, vj, qj, vk, qk,
                               input bit cv, input int unsigned ct, cd, input bit dr);
    mentry_t nxt [DEPTH];
    disp_t   d;
    int      fi, si;
    issue_valid = iv;
    issue_op    = OP_W'(op);
    issue_vj    = vj;
    issue_qj    = TAG_W'(qj);
    issue_vk    = vk;
    issue_qk    = TAG_W'(qk);
    cdb_valid   = cv;
    cdb_tag     = TAG_W'(ct);
    cdb_data    = cd;
    disp_ready  = dr;
    fi = modelFree();
    si = modelSelect();
    sq.push_back(modelStatus());
    if (si >= 0 && dr) begin
      d.op  = mdl[si].op;
      d.vj  = mdl[si].vj;
      d.vk  = mdl[si].vk;
      d.tag = TAG_BASE + si;
      dq.push_back(d);
    end
    nxt = mdl;
    for (int i = 0; i < DEPTH; i++) begin
      if (mdl[i].valid && cv && mdl[i].qj != 0 && mdl[i].qj == ct) begin
        nxt[i].vj = cd;
        nxt[i].qj = 0;
      end
      if (mdl[i].valid && cv && mdl[i].qk != 0 && mdl[i].qk == ct) begin
        nxt[i].vk = cd;
        nxt[i].qk = 0;
      end
    end
    if (si >= 0 && dr) nxt[si].valid = 1'b0;
    if (iv && fi >= 0) begin
      issue_count++;
      nxt[fi].valid = 1'b1;
      nxt[fi].op    = op % (1 << OP_W);
      nxt[fi].vj    = (cv && qj != 0 && qj == ct) ? cd : vj;
      nxt[fi].qj    = (cv && qj != 0 && qj == ct) ? 0 : qj;
      nxt[fi].vk    = (cv && qk != 0 && qk == ct) ? cd : vk;
      nxt[fi].qk    = (cv && qk != 0 && qk == ct) ? 0 : qk;
      nxt[fi].seq   = issue_count;
    end
    mdl = nxt;
    @(posedge clk);
    #1;
  endtask

  // Asserts reset for one full cycle with the FU willing, so any dispatch here is an error.
  task automatic resetDut();
    checkOutput("drain_before_reset", 64'(dq.size()), 64'd0);
    rst        = 1'b1;
    disp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '{default: 0};
    sq.push_back(modelStatus());
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic int unsigned pickQ(input int unsigned alloc);
    int unsigned t;
    if ($urandom_range(0, 1) == 0) return 0;
    do t = $urandom_range(1, 8); while (t == alloc);
    return t;
  endfunction

  // Monitor: compares every cycle's status and pops the scoreboard on each observed dispatch.
  initial begin
    status_t s;
    disp_t   d;
    forever begin
      @(negedge clk);
      if (sq.size() > 0) begin
        s = sq.pop_front();
        checkOutput("issue_ready", 64'(issue_ready), 64'(s.ready_o));
        checkOutput("issue_tag", 64'(issue_tag), 64'(s.tag));
        checkOutput("occupancy", 64'(occupancy), 64'(s.occ));
        checkOutput("full", 64'(full), 64'(s.full_o));
        checkOutput("empty", 64'(empty), 64'(s.empty_o));
        checkOutput("disp_valid", 64'(disp_valid), 64'(s.dvalid));
        checkOutput("disp_op_sel", 64'(disp_op), 64'(s.dop));
        checkOutput("disp_vj_sel", 64'(disp_vj), 64'(s.dvj));
        checkOutput("disp_vk_sel", 64'(disp_vk), 64'(s.dvk));
        checkOutput("disp_tag_sel", 64'(disp_tag), 64'(s.dtag));
        if (disp_valid && disp_ready) begin
          if (dq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_dispatch: got tag 0x%0h expected no dispatch at %0t",
                     disp_tag, $time);
          end else begin
            d = dq.pop_front();
            checkOutput("sb_op", 64'(disp_op), 64'(d.op));
            checkOutput("sb_vj", 64'(disp_vj), 64'(d.vj));
            checkOutput("sb_vk", 64'(disp_vk), 64'(d.vk));
            checkOutput("sb_tag", 64'(disp_tag), 64'(d.tag));
          end
        end
      end
    end
  end

  initial begin
    int          fi;
    int unsigned alloc;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '{default: 0};
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    resetDut();
    checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
    checkOutput("rst_empty", 64'(empty), 64'd1);
    checkOutput("rst_disp_valid", 64'(disp_valid), 64'd0);

    // Ready issue dispatches the next cycle and the station drains.
    checkOutput("first_issue_tag", 64'(issue_tag), 64'd1);
    applyStimulus(1, 1, 5, 0, 7, 0, 0, 0, 0, 0);
    checkOutput("first_disp_vj", 64'(disp_vj), 64'd5);
    checkOutput("first_disp_tag", 64'(disp_tag), 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("first_drained", 64'(occupancy), 64'd0);

    // Pending rs1 woken by a later broadcast.
    applyStimulus(1, 2, 0, 3, 9, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 32'hAA, 1);
    checkOutput("wake_disp_vj", 64'(disp_vj), 64'hAA);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // rs2 captured by the issue-cycle bypass.
    applyStimulus(1, 3, 32'h11, 0, 0, 2, 1, 2, 32'h55, 0);
    checkOutput("bypass_disp_vk", 64'(disp_vk), 64'h55);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Fill with pending entries, then dispatch while a stalled issue waits for room.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, i, i, 9 + i, i, 0, 0, 0, 0, 1);
    checkOutput("full_flag", 64'(full), 64'd1);
    checkOutput("full_issue_tag", 64'(issue_tag), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 32'h99, 1);
    applyStimulus(1, 6, 32'h60, 0, 32'h61, 0, 0, 0, 0, 1);
    applyStimulus(1, 6, 32'h60, 0, 32'h61, 0, 0, 0, 0, 0);
    checkOutput("refill_occupancy", 64'(occupancy), 64'd4);
    resetDut();

    // Two ready entries around a pending one, held, then released in order.
    applyStimulus(1, 4, 32'h10, 0, 32'h20, 0, 0, 0, 0, 0);
    applyStimulus(1, 5, 32'h30, 12, 32'h40, 0, 0, 0, 0, 0);
    applyStimulus(1, 6, 32'h50, 0, 32'h60, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("hold_second_tag", 64'(disp_tag), 64'd3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 12, 32'h12, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Older pending entry in a higher slot than a younger ready one.
    applyStimulus(1, 1, 1, 0, 1, 0, 0, 0, 0, 1);
    applyStimulus(1, 2, 2, 13, 2, 0, 0, 0, 0, 1);
    applyStimulus(1, 3, 3, 0, 3, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 13, 32'h77, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    resetDut();

    for (int c = 0; c < 3000; c++) begin
      if (c == 1000 || c == 2000) resetDut();
      fi    = modelFree();
      alloc = (fi >= 0) ? int'(TAG_BASE + fi) : 0;
      applyStimulus($urandom_range(0, 99) < 60, $urandom_range(0, 7), $urandom, pickQ(alloc),
                    $urandom, pickQ(alloc), $urandom_range(0, 1) == 1, $urandom_range(0, 8),
                    $urandom, $urandom_range(0, 99) < 70);
    end

    checkOutput("final_status_queue", 64'(sq.size()), 64'd0);
    checkOutput("final_dispatch_queue", 64'(dq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
